// File: rtl/msx_fdc_glue.sv
// MSX disk-cartridge glue: decodes slot accesses into ROM reads, WD1793
// register accesses and the cartridge control registers (Philips or National
// layout), with motor auto-off timer and per-drive disk-change latches.
module msx_fdc_glue #(
    parameter int          DRIVES        = 2,
    parameter int          MAP_MODE      = 0,
    parameter logic [23:0] MOTOR_TIMEOUT = 24'd3000000,
    parameter int          ROM_AW        = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [15:0]       addr,
    input  logic [7:0]        d_from_cpu,
    output logic [7:0]        d_to_cpu,
    input  logic              sltsl_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [DRIVES-1:0] img_mounted,
    input  logic [DRIVES-1:0] img_size_nz,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              fdc_cs,
    output logic              fdc_rd,
    output logic              fdc_wr,
    output logic [1:0]        fdc_addr,
    input  logic [7:0]        fdc_dout,
    input  logic              fdc_drq,
    input  logic              fdc_intrq,
    output logic [1:0]        drive_sel,
    output logic              side,
    output logic              motor,
    output logic              fdc_ready
);

    logic        win, page;
    logic [2:0]  off;
    logic        wr_prev, rd_prev;
    logic        wr_start, rd_start, rd_rise;
    logic        ctl_commit, stat_sel, stat_clr;
    logic        side_en, sel_en, mot_en, w_side, w_motor;
    logic [1:0]  w_sel;
    logic [23:0] cnt;
    logic [3:0]  chg, loaded, mnt4, nz4;
    logic        chg_sel;
    logic        unused_ok;

    assign win  = ~sltsl_n & (addr[15:14] == 2'b01);
    assign page = (MAP_MODE == 0) ? (addr[13:3] == 11'h7FF) : (addr[13:3] == 11'h7F7);
    assign off  = addr[2:0];

    assign rom_addr = addr[ROM_AW-1:0];
    assign fdc_cs   = win & page & ~off[2];
    assign fdc_rd   = fdc_cs & ~rd_n;
    assign fdc_wr   = fdc_cs & ~wr_n;
    assign fdc_addr = addr[1:0];

    // Strobe edges are detected on the bus-rate enable so a held strobe commits once.
    assign wr_start = clk_en & ~wr_n & wr_prev;
    assign rd_start = clk_en & ~rd_n & rd_prev;
    assign rd_rise  = clk_en & rd_n & ~rd_prev;

    assign stat_sel = (MAP_MODE == 0) ? (off == 3'd7) : (off == 3'd4);
    assign stat_clr = rd_rise & win & page & stat_sel;

    // Widen per-drive inputs to the 4-drive maximum; unused drives stay zero.
    always_comb begin
        mnt4 = '0;
        nz4  = '0;
        mnt4[DRIVES-1:0] = img_mounted;
        nz4[DRIVES-1:0]  = img_size_nz;
    end

    assign chg_sel   = chg[drive_sel];
    assign fdc_ready = motor & loaded[drive_sel] & (int'(drive_sel) < DRIVES);
    assign unused_ok = &{1'b0, d_from_cpu[6:4]};

    // Decode which control fields a write to the current address updates.
    always_comb begin
        side_en = 1'b0;
        sel_en  = 1'b0;
        mot_en  = 1'b0;
        w_side  = d_from_cpu[0];
        w_sel   = d_from_cpu[1:0];
        w_motor = d_from_cpu[7];
        if (MAP_MODE == 0) begin
            side_en = (off == 3'd4);
            sel_en  = (off == 3'd5);
            mot_en  = (off == 3'd5);
        end else begin
            side_en = (off == 3'd4);
            sel_en  = (off == 3'd4);
            mot_en  = (off == 3'd4);
            w_side  = d_from_cpu[2];
            w_motor = d_from_cpu[3];
        end
    end

    assign ctl_commit = wr_start & win & page & (side_en | sel_en | mot_en);

    // CPU read mux: ROM, WD registers or control/status; FF outside the slot window.
    always_comb begin
        d_to_cpu = 8'hFF;
        if (win) begin
            if (!page)
                d_to_cpu = rom_q;
            else if (!off[2])
                d_to_cpu = fdc_dout;
            else if (MAP_MODE == 0) begin
                case (off)
                    3'd4:    d_to_cpu = {7'h7F, ~side};
                    3'd5:    d_to_cpu = {motor, 5'b11111, drive_sel};
                    3'd7:    d_to_cpu = {~fdc_drq, ~fdc_intrq, ~chg_sel, 5'h1F};
                    default: d_to_cpu = 8'hFF;
                endcase
            end else if (off == 3'd4)
                d_to_cpu = {fdc_drq, fdc_intrq, chg_sel, 5'h00};
        end
    end

    // Strobe history and the side / drive select registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev   <= 1'b1;
            rd_prev   <= 1'b1;
            side      <= 1'b0;
            drive_sel <= 2'd0;
        end else if (clk_en) begin
            wr_prev <= wr_n;
            rd_prev <= rd_n;
            if (ctl_commit & side_en) side <= w_side;
            if (ctl_commit & sel_en)  drive_sel <= w_sel;
        end
    end

    // Motor request with inactivity countdown; the tick that reaches zero drops the motor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor <= 1'b0;
            cnt   <= 24'd0;
        end else if (clk_en) begin
            if (ctl_commit & mot_en & ~w_motor) begin
                motor <= 1'b0;
            end else if (ctl_commit & mot_en & w_motor & ~motor) begin
                motor <= 1'b1;
                cnt   <= MOTOR_TIMEOUT;
            end else if (fdc_cs & (rd_start | wr_start)) begin
                cnt <= MOTOR_TIMEOUT;
            end else if (motor && cnt != 24'd0) begin
                cnt <= cnt - 24'd1;
                if (cnt == 24'd1) motor <= 1'b0;
            end
        end
    end

    // Disk-change and loaded latches; a mount pulse beats a same-cycle status clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg    <= 4'd0;
            loaded <= 4'd0;
        end else if (clk_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mnt4[i]) begin
                    chg[i]    <= 1'b1;
                    loaded[i] <= nz4[i];
                end else if (stat_clr && drive_sel == 2'(i)) begin
                    chg[i] <= 1'b0;
                end
            end
        end
    end

endmodule
